// File: rtl/hdmi_wave_pkg.sv
// Shared types and helpers for the multi-channel HDMI waveform write path.
//   state_t   : write-side FSM states
//   PIX_BG    : background colour index
//   ch_colour : colour index a trace is drawn with (channel k -> k+1)
package hdmi_wave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCALE,
        PLOT,
        NEXT,
        WAIT_SWAP
    } state_t;

    localparam int unsigned PIX_BG = 0;

    function automatic int unsigned ch_colour(input int unsigned ch);
        return ch + 1;
    endfunction

endpackage

// File: rtl/hdmi_wave_writer_row_scale.sv
// Registered sample-to-row scaling: row = HEIGHT-1 - ((val*HEIGHT) >> VAL_RES).
// Ports:
//   clkWR, rstn : clock, async active-low reset
//   en          : load a new row from val this cycle, otherwise hold
//   val         : unsigned sample value
//   row         : screen row (0 = top), registered
module wave_row_scale #(
    parameter int unsigned VAL_RES     = 16,
    parameter int unsigned HEIGHT      = 480,
    parameter int unsigned LOG2_HEIGHT = 9
) (
    input  logic                   clkWR,
    input  logic                   rstn,
    input  logic                   en,
    input  logic [VAL_RES-1:0]     val,
    output logic [LOG2_HEIGHT-1:0] row
);

    localparam int unsigned PROD_W = VAL_RES + LOG2_HEIGHT;

    logic [PROD_W-1:0]      prod;
    logic [LOG2_HEIGHT-1:0] row_next;

    // Full-scale value maps to the top row, zero to the bottom row.
    always_comb begin
        prod     = PROD_W'(val) * PROD_W'(HEIGHT);
        row_next = LOG2_HEIGHT'(HEIGHT - 1) - LOG2_HEIGHT'(prod >> VAL_RES);
    end

    always_ff @(posedge clkWR or negedge rstn) begin
        if (!rstn) begin
            row <= '0;
        end else if (en) begin
            row <= row_next;
        end
    end

endmodule

// File: rtl/hdmi_wave_writer.sv
// Multi-channel waveform writer: one sample vector per column, each enabled
// channel drawn as a vertical span from its previous row to its new row into
// a ping-pong framebuffer. Buffers swap only on vblank from the read side.
// Ports:
//   clkWR, rstn           : clock, async active-low reset
//   s_valid/s_ready/s_data: sample vector handshake (ch k at [k*VAL_RES +: VAL_RES])
//   ch_en                 : per-channel draw enable, captured on accept
//   vblank                : frame-end pulse, honoured only while waiting to swap
//   wr_buf_sel            : buffer being written
//   mem_en/mem_we/mem_addr/mem_wdata : write-only framebuffer port
//   frame_done            : frame complete, waiting for vblank
//   busy                  : FSM not idle
module hdmi_wave_writer
    import hdmi_wave_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned VAL_RES     = 16,
    parameter int unsigned WIDTH       = 640,
    parameter int unsigned HEIGHT      = 480,
    parameter int unsigned LOG2_WIDTH  = 10,
    parameter int unsigned LOG2_HEIGHT = 9,
    parameter int unsigned ADDR_WIDTH  = 19,
    parameter int unsigned PIX_W       = 2
) (
    input  logic                      clkWR,
    input  logic                      rstn,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [NUM_CH*VAL_RES-1:0] s_data,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic                      vblank,
    output logic                      wr_buf_sel,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_WIDTH:0]       mem_addr,
    output logic [PIX_W-1:0]          mem_wdata,
    output logic                      frame_done,
    output logic                      busy
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t                    state_q, state_d;
    logic [LOG2_WIDTH-1:0]     x_q, x_d;
    logic [LOG2_HEIGHT-1:0]    y_q, y_d;
    logic [LOG2_HEIGHT-1:0]    cur_q, cur_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic                      first_q, first_d;
    logic [NUM_CH*VAL_RES-1:0] data_q, data_d;
    logic [NUM_CH-1:0]         en_q, en_d;
    logic [NUM_CH-1:0]         pv_q, pv_d;
    logic [LOG2_HEIGHT-1:0]    pr_q [NUM_CH];
    logic [LOG2_HEIGHT-1:0]    pr_d [NUM_CH];
    logic                      buf_q, buf_d;

    logic                      s_ready_d, busy_d, frame_done_d, mem_we_d;
    logic [ADDR_WIDTH:0]       mem_addr_d;
    logic [PIX_W-1:0]          mem_wdata_d;

    logic                      wr;
    logic [LOG2_HEIGHT-1:0]    wr_y;
    logic [PIX_W-1:0]          wr_pix;
    logic                      scale_en;
    logic [VAL_RES-1:0]        val_sel;
    logic [LOG2_HEIGHT-1:0]    row;
    logic [CH_W:0]             first_en, next_en;
    logic                      single;
    logic [ADDR_WIDTH-1:0]     pix_addr;

    // Lowest enabled channel at or above 'from'; MSB flags that one exists.
    function automatic logic [CH_W:0] find_en(input logic [NUM_CH-1:0] en,
                                               input int unsigned from);
        logic [CH_W:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!r[CH_W] && en[i] && (i >= from)) begin
                r = {1'b1, CH_W'(i)};
            end
        end
        return r;
    endfunction

    assign val_sel = data_q[32'(ch_q) * VAL_RES +: VAL_RES];

    wave_row_scale #(
        .VAL_RES     (VAL_RES),
        .HEIGHT      (HEIGHT),
        .LOG2_HEIGHT (LOG2_HEIGHT)
    ) u_scale (
        .clkWR (clkWR),
        .rstn  (rstn),
        .en    (scale_en),
        .val   (val_sel),
        .row   (row)
    );

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cur_d    = cur_q;
        ch_d     = ch_q;
        first_d  = first_q;
        data_d   = data_q;
        en_d     = en_q;
        pv_d     = pv_q;
        pr_d     = pr_q;
        buf_d    = buf_q;
        wr       = 1'b0;
        wr_y     = y_q;
        wr_pix   = PIX_W'(PIX_BG);
        scale_en = 1'b0;
        single   = (x_q == '0) || !pv_q[ch_q];
        first_en = find_en(en_q, 0);
        next_en  = find_en(en_q, 32'(ch_q) + 1);

        unique case (state_q)
            IDLE: begin
                if (s_valid && s_ready) begin
                    data_d  = s_data;
                    en_d    = ch_en;
                    // A disabled trace loses its history so it restarts as a point.
                    pv_d    = pv_q & ch_en;
                    y_d     = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                wr = 1'b1;
                if (y_q == LOG2_HEIGHT'(HEIGHT - 1)) begin
                    if (first_en[CH_W]) begin
                        ch_d    = first_en[CH_W-1:0];
                        state_d = SCALE;
                    end else begin
                        state_d = NEXT;
                    end
                end else begin
                    y_d = y_q + LOG2_HEIGHT'(1);
                end
            end
            SCALE: begin
                scale_en = 1'b1;
                first_d  = 1'b1;
                state_d  = PLOT;
            end
            PLOT: begin
                // Span starts at the previous row and walks toward the new one.
                wr     = 1'b1;
                wr_pix = PIX_W'(ch_colour(32'(ch_q)));
                if (first_q) begin
                    wr_y = single ? row : pr_q[ch_q];
                end else begin
                    wr_y = cur_q;
                end
                if (wr_y == row) begin
                    pr_d[ch_q] = row;
                    pv_d[ch_q] = 1'b1;
                    if (next_en[CH_W]) begin
                        ch_d    = next_en[CH_W-1:0];
                        state_d = SCALE;
                    end else begin
                        state_d = NEXT;
                    end
                end else begin
                    first_d = 1'b0;
                    cur_d   = (wr_y < row) ? wr_y + LOG2_HEIGHT'(1)
                                           : wr_y - LOG2_HEIGHT'(1);
                end
            end
            NEXT: begin
                if (x_q == LOG2_WIDTH'(WIDTH - 1)) begin
                    state_d = WAIT_SWAP;
                end else begin
                    x_d     = x_q + LOG2_WIDTH'(1);
                    state_d = IDLE;
                end
            end
            WAIT_SWAP: begin
                if (vblank) begin
                    buf_d   = ~buf_q;
                    x_d     = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pix_addr     = ADDR_WIDTH'(wr_y) * ADDR_WIDTH'(WIDTH) + ADDR_WIDTH'(x_q);
        s_ready_d    = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == WAIT_SWAP);
        mem_we_d     = wr;
        mem_addr_d   = wr ? {buf_q, pix_addr} : '0;
        mem_wdata_d  = wr ? wr_pix : '0;
    end

    // State, datapath and output registers.
    always_ff @(posedge clkWR or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            cur_q      <= '0;
            ch_q       <= '0;
            first_q    <= 1'b0;
            data_q     <= '0;
            en_q       <= '0;
            pv_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pr_q[i] <= '0;
            end
            buf_q      <= 1'b0;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cur_q      <= cur_d;
            ch_q       <= ch_d;
            first_q    <= first_d;
            data_q     <= data_d;
            en_q       <= en_d;
            pv_q       <= pv_d;
            pr_q       <= pr_d;
            buf_q      <= buf_d;
            s_ready    <= s_ready_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
            mem_en     <= mem_we_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

    assign wr_buf_sel = buf_q;

endmodule
